switch_debouncer: RTL
=====================

# switch_debouncer

Conditions raw DE2 slide-switch and push-button inputs before they drive the storage-element stages of the lab top level. Each channel is synchronised to the 50 MHz board clock and filtered by a per-channel stability counter. The block produces a clean level, plus optional one-cycle rise/fall strobes. Downstream latches and flip-flops then see a bounce-free D and a bounce-free clock/enable source instead of raw mechanical contacts.

## Interface
- WIDTH, 16, number of independent input channels.
- STABLE_CYCLES, 500000, consecutive mismatching samples required before a level change is accepted (10 ms at 50 MHz); legal range 2 to 2^24.
- Clk  input  1  board clock, all logic on rising edge.
- Resetn  input  1  synchronous, active-low reset, sampled on rising Clk.
- raw_in  input  WIDTH  asynchronous switch/key levels.
- db_out  output  WIDTH  debounced level per channel.
- rise_pulse  output  WIDTH  one-cycle strobe when db_out goes 0->1.
- fall_pulse  output  WIDTH  one-cycle strobe when db_out goes 1->0.

## Operation
- Each channel has:
  - a 2-flop synchroniser, sync1 then sync2;
  - a counter cnt of width CNT_W = clog2(STABLE_CYCLES);
  - the registered level db.
- Per channel, per rising Clk with Resetn=1:
  - sync2 == db: cnt <= 0 (any bounce back restarts the filter).
  - sync2 != db and cnt < STABLE_CYCLES-1: cnt <= cnt+1.
  - sync2 != db and cnt == STABLE_CYCLES-1: db <= sync2, cnt <= 0.
- Channels are fully independent. Simultaneous changes on several channels are each filtered on their own count.
- rise_pulse[i] and fall_pulse[i] are registered and asserted in the same cycle db[i] changes, for exactly one cycle.
- rise_pulse[i] and fall_pulse[i] are never both high.
- Counter never wraps. It saturates logically because it is cleared on acceptance.
- Resetn=0 at any edge, including mid-count: sync1, sync2, cnt, db, rise_pulse and fall_pulse all go to 0 at that edge. After reset release, a raw input already at 1 is accepted as a normal 0->1 change and produces a rise_pulse.

## Timing
- Reset values: db_out=0, rise_pulse=0, fall_pulse=0.
- Let E be the first edge at which sync1 samples the new raw level. If the level then holds:
  - sync2 updates at E+1;
  - cnt increments at edges E+2 through E+STABLE_CYCLES;
  - db_out and the strobe update at edge E+STABLE_CYCLES+1.
- Glitch rejection: a raw change that reverts before STABLE_CYCLES consecutive mismatching samples never reaches db_out.
- No combinational path from raw_in to any output. All outputs are registered.

## Configuration
- SWITCH_DEBOUNCER_PULSE_EN defined:
  - rise/fall strobe logic and registers are built;
  - behaviour is as described above.
- Not defined:
  - strobe registers are not built;
  - rise_pulse and fall_pulse are tied to constant 0;
  - db_out behaviour and timing are identical.

## Structure
- Package switch_debouncer_pkg holds:
  - default constants DB_WIDTH_DEFAULT=16 and DB_STABLE_DEFAULT=500000;
  - a clog2-based CNT_W helper function;
  - CLK_HZ=50000000, used to derive STABLE_CYCLES from milliseconds.
- One sub-module, debounce_channel:
  - single-bit synchroniser, counter and strobe logic;
  - replicated WIDTH times by a generate loop in switch_debouncer;
  - the top module only does instantiation and bus assembly.

## Test plan
All scenarios use WIDTH=2 and STABLE_CYCLES=4 unless noted.
- Reset: hold Resetn=0 for 3 cycles with raw_in=2'b11 -> db_out=0, strobes 0 during reset. Release -> db_out=2'b11 exactly 5 edges after the first sync1 sample, rise_pulse=2'b11 for one cycle.
- Clean step: raw_in[0] 0->1 and held -> db_out[0] rises at edge E+5, rise_pulse[0]=1 only at E+5, fall_pulse stays 0.
- Bounce: raw_in[0] toggles 1,0,1,0 on successive cycles, then settles at 1 -> no change until 4 consecutive mismatch samples. Only one rise_pulse is produced.
- Short glitch: raw_in[1] high for 3 cycles, then back low -> db_out[1] stays 0, no strobes.
- Independent channels: raw_in[0] rises at edge 10, raw_in[1] rises at edge 12 -> db_out bits change at edges 15 and 17 respectively.
- Reset mid-count: raw_in[0] high, Resetn=0 when cnt=2 -> cnt and db cleared. After release, the full E+5 latency applies again. With SWITCH_DEBOUNCER_PULSE_EN undefined, all strobes stay 0 throughout.

Source files
------------

// File: rtl/switch_debouncer_pkg.sv
// switch_debouncer_pkg: shared constants and sizing helpers for the switch debouncer.
// Counter width and millisecond-to-cycle conversion are derived from the 50 MHz board clock.
package switch_debouncer_pkg;

    localparam int CLK_HZ            = 50000000;
    localparam int DB_WIDTH_DEFAULT  = 16;
    localparam int DB_STABLE_DEFAULT = 500000;

    function automatic int cnt_w(input int stable_cycles);
        return (stable_cycles < 2) ? 1 : $clog2(stable_cycles);
    endfunction

    function automatic int ms_to_cycles(input int ms);
        return (CLK_HZ / 1000) * ms;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: one-bit synchroniser, stability counter and optional edge strobes.
// Strobe registers exist only when SWITCH_DEBOUNCER_PULSE_EN is defined.
module debounce_channel
    import switch_debouncer_pkg::*;
#(
    parameter int STABLE_CYCLES = DB_STABLE_DEFAULT
) (
    input  logic Clk,
    input  logic Resetn,
    input  logic raw,
    output logic db,
    output logic rise,
    output logic fall
);

    localparam int CW = cnt_w(STABLE_CYCLES);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;
    logic          accept;

    assign accept = (sync2 != db) && (cnt == CW'(STABLE_CYCLES - 1));

    // Any sample agreeing with db restarts the filter; acceptance also clears it, so cnt never wraps.
    always_ff @(posedge Clk) begin
        if (!Resetn) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            db    <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            cnt   <= (sync2 == db || accept) ? '0 : cnt + 1'b1;
            if (accept)
                db <= sync2;
        end
    end

`ifdef SWITCH_DEBOUNCER_PULSE_EN
    always_ff @(posedge Clk) begin
        if (!Resetn) begin
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            rise <= accept & sync2;
            fall <= accept & ~sync2;
        end
    end
`else
    assign rise = 1'b0;
    assign fall = 1'b0;
`endif

endmodule

// File: rtl/switch_debouncer.sv
// switch_debouncer: WIDTH independent debounce channels for raw DE2 switches and keys.
// Rise/fall strobes are built only when SWITCH_DEBOUNCER_PULSE_EN is defined, else tied to 0.
module switch_debouncer
    import switch_debouncer_pkg::*;
#(
    parameter int WIDTH         = DB_WIDTH_DEFAULT,
    parameter int STABLE_CYCLES = DB_STABLE_DEFAULT
) (
    input  logic             Clk,
    input  logic             Resetn,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] db_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        debounce_channel #(
            .STABLE_CYCLES(STABLE_CYCLES)
        ) u_ch (
            .Clk   (Clk),
            .Resetn(Resetn),
            .raw   (raw_in[i]),
            .db    (db_out[i]),
            .rise  (rise_pulse[i]),
            .fall  (fall_pulse[i])
        );
    end

endmodule
